// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared FSM state type and counter-width helper for the ccff chain loader
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ccff_state_e;

  // Width that can hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// rtl/ccff_word_shifter.sv - holds one bitstream word and presents it LSB first, one bit per shift
module ccff_word_shifter #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic              full,
  output logic              bit_out,
  output logic              last_bit
);
  import ccff_pkg::*;

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_d, word_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              full_d, full_q;

  // A load in the same cycle as the final shift refills the holder without a gap.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (flush) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (load) begin
      word_d = load_data;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (shift && full_q) begin
      if (idx_q == IDX_LAST) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign full     = full_q;
  assign bit_out  = word_q[idx_q];
  assign last_bit = full_q && (idx_q == IDX_LAST);

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - streams a bitstream into a ccff chain; CCFF_READBACK_EN adds tail readback
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  input  logic [WORD_W-1:0] bs_data,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  ccff_state_e      state_d, state_q;
  logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
  logic             sh_full, sh_bit, sh_last;
  logic             pass_start, all_shifted, room, accept, shift, flush;

  ccff_word_shifter #(.WORD_W(WORD_W)) u_shifter (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .flush      (flush),
    .load       (accept),
    .shift      (shift),
    .load_data  (bs_data),
    .full       (sh_full),
    .bit_out    (sh_bit),
    .last_bit   (sh_last)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pass_start  = (state_q == ST_IDLE) && start;
    all_shifted = (bit_cnt_q == CNT_MAX);
    // A new word is only taken if at least one of its bits will still fit in the chain.
    room        = !all_shifted &&
                  (!sh_full || (sh_last && ((bit_cnt_q + CNT_W'(1)) < CNT_MAX)));
    bs_ready    = (state_q == ST_LOAD) && !abort && room;
    accept      = bs_valid && bs_ready;
    shift       = (state_q == ST_LOAD) && sh_full && !all_shifted;
    flush       = (state_q != ST_LOAD) || abort || all_shifted;

    case (state_q)
      ST_IDLE: begin
        if (pass_start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (shift) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (abort)            state_d = ST_IDLE;
        else if (all_shifted) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign ccff_shift_en = shift;
  assign ccff_head     = shift && sh_bit;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

`ifdef CCFF_READBACK_EN
  localparam int RB_IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [RB_IDX_W-1:0] RB_LAST = RB_IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0]   rb_acc_d, rb_acc_q, rb_data_d, rb_data_q, rb_word;
  logic [RB_IDX_W-1:0] rb_idx_d, rb_idx_q;
  logic                rb_valid_d, rb_valid_q;

  // Old chain contents fall out of the tail while the new bits go in at the head.
  always_comb begin
    rb_acc_d   = rb_acc_q;
    rb_idx_d   = rb_idx_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    rb_word    = rb_acc_q | (WORD_W'(ccff_tail) << rb_idx_q);
    if (pass_start) begin
      rb_acc_d = '0;
      rb_idx_d = '0;
    end else if (shift) begin
      if ((rb_idx_q == RB_LAST) || ((bit_cnt_q + CNT_W'(1)) == CNT_MAX)) begin
        rb_data_d  = rb_word;
        rb_valid_d = 1'b1;
        rb_acc_d   = '0;
        rb_idx_d   = '0;
      end else begin
        rb_acc_d = rb_word;
        rb_idx_d = rb_idx_q + RB_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      rb_acc_q   <= '0;
      rb_idx_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_acc_q   <= rb_acc_d;
      rb_idx_q   <= rb_idx_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_valid    = 1'b0;
  assign rb_data     = '0;
`endif

endmodule
